// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush controls for F/D/E/M,
// multi-cycle MDU sequencing in E, and registered E-stage forward selects.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_rs1,
    input  logic [4:0] D_rs2,
    input  logic       D_use_rs1,
    input  logic       D_use_rs2,
    input  logic [4:0] E_rd,
    input  logic       E_reg_write,
    input  logic       E_is_load,
    input  logic       E_is_mdu,
    input  logic [4:0] M_rd,
    input  logic       M_reg_write,
    input  logic       jb,
    output logic       stall_pc,
    output logic       stall_D,
    output logic       flush_D,
    output logic       bubble_E,
    output logic       hold_E,
    output logic       bubble_M,
    output logic [1:0] E_rs1_fwd,
    output logic [1:0] E_rs2_fwd,
    output logic       mdu_done,
    output logic       busy
);

    // state  | meaning
    // IDLE   | normal flow; resolves jb, MDU start and load-use
    // MDU    | MDU op occupies E; cnt counts remaining stall cycles
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MDU  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       rs1_fwd_nx;
    logic [1:0]       rs2_fwd_nx;
    logic             load_use;

    assign load_use = E_is_load && E_reg_write && (E_rd != 5'd0) &&
                      ((D_use_rs1 && (D_rs1 == E_rd)) ||
                       (D_use_rs2 && (D_rs2 == E_rd)));

    // A load in E cannot forward; its dependent is handled by the bubble and
    // later picks the value up from W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_rs) begin
            if (E_reg_write && (E_rd != 5'd0) && (E_rd == rs) && !E_is_load)
                sel = FWD_M;
            else if (M_reg_write && (M_rd != 5'd0) && (M_rd == rs))
                sel = FWD_W;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= CNT_ZERO;
            E_rs1_fwd <= FWD_RF;
            E_rs2_fwd <= FWD_RF;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            E_rs1_fwd <= rs1_fwd_nx;
            E_rs2_fwd <= rs2_fwd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (!jb && E_is_mdu) begin
                    state_nx = S_MDU;
                    cnt_nx   = CNT_INIT;
                end
            end
            S_MDU: begin
                if (cnt != CNT_ZERO)
                    cnt_nx = cnt - CNT_ONE;
                else
                    state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        stall_pc = 1'b0;
        stall_D  = 1'b0;
        flush_D  = 1'b0;
        bubble_E = 1'b0;
        hold_E   = 1'b0;
        bubble_M = 1'b0;
        mdu_done = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (jb) begin
                    flush_D  = 1'b1;
                    bubble_E = 1'b1;
                end else if (E_is_mdu) begin
                    stall_pc = 1'b1;
                    stall_D  = 1'b1;
                    hold_E   = 1'b1;
                    bubble_M = 1'b1;
                end else if (load_use) begin
                    stall_pc = 1'b1;
                    stall_D  = 1'b1;
                    bubble_E = 1'b1;
                end
            end
            S_MDU: begin
                busy = 1'b1;
                if (cnt != CNT_ZERO) begin
                    stall_pc = 1'b1;
                    stall_D  = 1'b1;
                    hold_E   = 1'b1;
                    bubble_M = 1'b1;
                end else begin
                    mdu_done = 1'b1;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_comb begin
        rs1_fwd_nx = fwd_sel(D_rs1, D_use_rs1);
        rs2_fwd_nx = fwd_sel(D_rs2, D_use_rs2);
        if (hold_E) begin
            rs1_fwd_nx = E_rs1_fwd;
            rs2_fwd_nx = E_rs2_fwd;
        end else if (bubble_E) begin
            rs1_fwd_nx = FWD_RF;
            rs2_fwd_nx = FWD_RF;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control/forward vectors are queued
// as each cycle's inputs are driven and compared when that cycle is sampled.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] D_rs1, D_rs2, E_rd, M_rd;
    logic       D_use_rs1, D_use_rs2, E_reg_write, E_is_load, E_is_mdu;
    logic       M_reg_write, jb;
    logic       stall_pc, stall_D, flush_D, bubble_E, hold_E, bubble_M;
    logic [1:0] E_rs1_fwd, E_rs2_fwd;
    logic       mdu_done, busy;

    logic [11:0] sb_q[$];
    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .E_rd(E_rd), .E_reg_write(E_reg_write), .E_is_load(E_is_load), .E_is_mdu(E_is_mdu),
        .M_rd(M_rd), .M_reg_write(M_reg_write), .jb(jb),
        .stall_pc(stall_pc), .stall_D(stall_D), .flush_D(flush_D), .bubble_E(bubble_E),
        .hold_E(hold_E), .bubble_M(bubble_M), .E_rs1_fwd(E_rs1_fwd), .E_rs2_fwd(E_rs2_fwd),
        .mdu_done(mdu_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_in();
        rst = 1'b0; jb = 1'b0;
        D_rs1 = 5'd0; D_rs2 = 5'd0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
        E_rd = 5'd0; E_reg_write = 1'b0; E_is_load = 1'b0; E_is_mdu = 1'b0;
        M_rd = 5'd0; M_reg_write = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        clear_in();
    endtask

    // ctl = {stall_pc, stall_D, flush_D, bubble_E, hold_E, bubble_M, mdu_done, busy}
    task automatic chk(input string tag, input logic [7:0] ctl, input logic [1:0] f1,
                       input logic [1:0] f2);
        logic [11:0] exp_v;
        logic [11:0] obs_v;
        sb_q.push_back({ctl, f1, f2});
        #4;
        exp_v = sb_q.pop_front();
        obs_v = {stall_pc, stall_D, flush_D, bubble_E, hold_E, bubble_M, mdu_done, busy,
                 E_rs1_fwd, E_rs2_fwd};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed ctl=%b fwd=%0d/%0d expected ctl=%b fwd=%0d/%0d",
                   tag, obs_v[11:4], obs_v[3:2], obs_v[1:0],
                   exp_v[11:4], exp_v[3:2], exp_v[1:0]);
        end
    endtask

    initial begin
        clear_in();
        rst = 1'b1;

        // reset held two cycles with jb and E_is_mdu active
        next_cycle(); rst = 1'b1; jb = 1'b1; E_is_mdu = 1'b1;
        next_cycle(); rst = 1'b1; jb = 1'b1; E_is_mdu = 1'b1;
        next_cycle();
        chk("reset", 8'b0000_0000, 2'd0, 2'd0);

        // load-use: one bubble, then dependent forwards from W
        next_cycle(); E_is_load = 1'b1; E_reg_write = 1'b1; E_rd = 5'd5;
        D_rs1 = 5'd5; D_use_rs1 = 1'b1;
        chk("load_use", 8'b1101_0000, 2'd0, 2'd0);
        next_cycle(); M_rd = 5'd5; M_reg_write = 1'b1; D_rs1 = 5'd5; D_use_rs1 = 1'b1;
        chk("load_use_after", 8'b0000_0000, 2'd0, 2'd0);

        // E vs M priority on rs2
        next_cycle(); E_rd = 5'd7; E_reg_write = 1'b1; M_rd = 5'd7; M_reg_write = 1'b1;
        D_rs2 = 5'd7; D_use_rs2 = 1'b1;
        chk("fwd_w_latched", 8'b0000_0000, 2'd2, 2'd0);
        next_cycle(); E_reg_write = 1'b1; M_reg_write = 1'b1; D_use_rs2 = 1'b1;
        chk("fwd_prio", 8'b0000_0000, 2'd0, 2'd1);
        // x0 then a disabled rs2 use
        next_cycle(); M_rd = 5'd9; M_reg_write = 1'b1; D_rs1 = 5'd9; D_use_rs1 = 1'b1;
        D_rs2 = 5'd9;
        chk("fwd_x0", 8'b0000_0000, 2'd0, 2'd0);
        next_cycle(); E_rd = 5'd3; E_reg_write = 1'b1; D_rs1 = 5'd3; D_use_rs1 = 1'b1;
        M_rd = 5'd4; M_reg_write = 1'b1; D_rs2 = 5'd4; D_use_rs2 = 1'b1;
        chk("fwd_use_off", 8'b0000_0000, 2'd2, 2'd0);

        // MDU op, MDU_LAT=4: three stall cycles, done on the fourth, fwd held
        next_cycle(); E_is_mdu = 1'b1; E_reg_write = 1'b1; E_rd = 5'd3;
        chk("mdu_c1", 8'b1100_1100, 2'd1, 2'd2);
        next_cycle(); E_is_mdu = 1'b1; jb = 1'b1; E_is_load = 1'b1; E_reg_write = 1'b1;
        E_rd = 5'd3; D_rs1 = 5'd3; D_use_rs1 = 1'b1;
        chk("mdu_c2_jb_ign", 8'b1100_1101, 2'd1, 2'd2);
        next_cycle(); E_is_mdu = 1'b1;
        chk("mdu_c3", 8'b1100_1101, 2'd1, 2'd2);
        next_cycle(); E_is_mdu = 1'b1; jb = 1'b1;
        chk("mdu_c4_done", 8'b0000_0011, 2'd1, 2'd2);
        next_cycle(); M_rd = 5'd6; M_reg_write = 1'b1; D_rs2 = 5'd6; D_use_rs2 = 1'b1;
        chk("mdu_after", 8'b0000_0000, 2'd0, 2'd0);

        // jb beats load-use and MDU start, and clears the forward selects
        next_cycle(); jb = 1'b1; E_is_mdu = 1'b1; E_is_load = 1'b1; E_reg_write = 1'b1;
        E_rd = 5'd6; D_rs1 = 5'd6; D_use_rs1 = 1'b1;
        M_rd = 5'd6; M_reg_write = 1'b1; D_rs2 = 5'd6; D_use_rs2 = 1'b1;
        chk("jb_wins", 8'b0011_0000, 2'd0, 2'd2);
        next_cycle();
        chk("jb_after", 8'b0000_0000, 2'd0, 2'd0);

        // reset during the second MDU cycle
        next_cycle(); E_is_mdu = 1'b1;
        chk("mdu_rst_c1", 8'b1100_1100, 2'd0, 2'd0);
        next_cycle(); rst = 1'b1;
        chk("mdu_rst_c2", 8'b1100_1101, 2'd0, 2'd0);
        next_cycle();
        chk("mdu_rst_idle", 8'b0000_0000, 2'd0, 2'd0);
        next_cycle();
        chk("mdu_rst_nodone1", 8'b0000_0000, 2'd0, 2'd0);
        next_cycle();
        chk("mdu_rst_nodone2", 8'b0000_0000, 2'd0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
